pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Generic elastic pipeline-stage register with valid/ready handshake, 2-entry skid buffer and flush.
//  Successor to the fixed-field stage registers. Sits between any two pipeline stages (IF/ID .. MEM/WB).
//  Carries an opaque packed payload and sustains full throughput, with in_ready driven from a flop.
// PARAMETERS
//  DATA_W  104  payload width in bits (default = pc4+alu_result+load_data+rd+RegWrite+ResultSrc)
//  CNT_W   32   perf counter width (used only with PIPE_STAGE_PERF_EN)
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  flush      in   1       kill all held entries (branch mispredict / trap)
//  in_valid   in   1       upstream payload valid
//  in_ready   out  1       stage can accept; registered (= !skid_valid)
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       downstream payload valid
//  out_ready  in   1       downstream accepts (0 = stall)
//  out_data   out  DATA_W  payload to next stage (direct from main flop)
//  stall_cnt  out  CNT_W   [PIPE_STAGE_PERF_EN only] cycles with out_valid && !out_ready
//  bubble_cnt out  CNT_W   [PIPE_STAGE_PERF_EN only] cycles with !out_valid
// BEHAVIOUR
//  - Reset (rst=1 at edge): main_valid=0, skid_valid=0, main/skid data=0, counters=0.
//    Observable after reset: out_valid=0, in_ready=1, out_data=0. Reset overrides flush and any handshake.
//  - Transfers: in_xfer = in_valid&&in_ready; out_xfer = out_valid&&out_ready. Latency 1 cycle in->out.
//  - States (pipe_pkg::skid_state_e), derived from {skid_valid,main_valid}:
//    EMPTY: no entries.
//           in_xfer -> FULL, main <= in_data.
//    FULL:  main only.
//           in_xfer && out_xfer  -> FULL, main <= in_data.
//           in_xfer && !out_xfer -> SKID, skid <= in_data.
//           !in_xfer && out_xfer -> EMPTY.
//    SKID:  main+skid, in_ready=0.
//           out_xfer -> FULL, main <= skid.
//           else hold.
//  - in_ready is 0 in SKID only; never combinationally depends on out_ready.
//  - out_data/out_valid stable while out_valid && !out_ready (no payload change under stall).
//  - flush=1 at edge: next state EMPTY (both valids 0). Any same-cycle in_xfer is dropped.
//    A same-cycle out_xfer still completes downstream. Data flops hold (don't care). in_ready=1 next cycle.
//  - No entry is ever lost or duplicated absent flush. Order strictly FIFO.
//  - in_data is ignored when in_valid=0. X on in_data must not propagate to out_valid.
// CONFIGURATION
//  PIPE_STAGE_PERF_EN defined:
//   - stall_cnt/bubble_cnt ports exist. Each increments by 1 per qualifying cycle.
//   - Saturating at 2^CNT_W-1 (no wrap). Cleared by rst only, not by flush.
//   - The cycle rst=1 is not counted.
//  PIPE_STAGE_PERF_EN undefined:
//   - Ports and counters absent. Datapath behaviour identical.
// STRUCTURE
//  - pipe_pkg: typedef enum logic[1:0] skid_state_e {EMPTY,FULL,SKID}.
//  - pipe_pkg: mem_wb_payload_t packed struct (pc4,alu_result,load_data,rd,RegWrite,ResultSrc), $bits=104.
//  - Sub-module pipe_sat_cnt #(CNT_W) (clk,rst,inc,count): saturating counter, instantiated twice under macro.
//  - Control: one valid-pair FSM. Datapath: two DATA_W flops + 2:1 main-input mux (in_data vs skid).
// TESTING
//  1 Reset: rst=1 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_data=0, counters=0.
//  2 Streaming: out_ready=1, in_valid=1, in_data=1,2,3,4 -> out_data 1,2,3,4 on cycles 1..4, in_ready held 1.
//  3 Stall/skid: send A,B with out_ready=0 -> FULL then SKID, in_ready=0, out_data=A held.
//    Raise out_ready -> A, then B, no loss.
//  4 Flush in SKID with in_valid=1,in_data=C -> next cycle out_valid=0, in_ready=1; C never appears.
//  5 Flush + out_xfer same cycle (FULL, data D) -> D counted delivered; state EMPTY after.
//  6 PERF_EN, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated).
//    bubble_cnt stops changing.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the elastic pipeline-stage register.
//   skid_state_e    : occupancy of a stage, encoded as {skid_valid, main_valid}
//   mem_wb_payload_t: MEM/WB payload layout; its width sets the default DATA_W
// -----------------------------------------------------------------------------
package pipe_pkg;

    // The encoding matches {skid_valid, main_valid}, so each valid bit can be
    // read directly from the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b11
    } skid_state_e;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] alu_result;
        logic [31:0] load_data;
        logic [4:0]  rd;
        logic        RegWrite;
        logic [1:0]  ResultSrc;
    } mem_wb_payload_t;

    localparam int PAYLOAD_W = $bits(mem_wb_payload_t);

endpackage

// File: rtl/pipe_sat_cnt.sv
// -----------------------------------------------------------------------------
// pipe_sat_cnt
// Saturating up-counter. It counts one per cycle while inc is high and holds
// at all-ones instead of wrapping. Only rst clears it.
// Ports:
//   clk   in  1      rising-edge clock
//   rst   in  1      synchronous active-high clear
//   inc   in  1      count this cycle
//   count out CNT_W  current count value
// -----------------------------------------------------------------------------
module pipe_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Elastic pipeline-stage register with a valid/ready handshake, a 2-entry skid
// buffer and flush. It sustains one transfer per cycle. in_ready comes straight
// from the state flop, so it never depends combinationally on out_ready.
// Optional build macro: PIPE_STAGE_PERF_EN adds the stall_cnt/bubble_cnt
// saturating performance counters.
// Ports:
//   clk        in  1       rising-edge clock
//   rst        in  1       synchronous active-high reset
//   flush      in  1       drop every held entry
//   in_valid   in  1       upstream payload valid
//   in_ready   out 1       stage can accept (registered)
//   in_data    in  DATA_W  upstream payload
//   out_valid  out 1       downstream payload valid
//   out_ready  in  1       downstream accepts
//   out_data   out DATA_W  payload from the main flop
//   stall_cnt  out CNT_W   [PIPE_STAGE_PERF_EN] cycles with out_valid && !out_ready
//   bubble_cnt out CNT_W   [PIPE_STAGE_PERF_EN] cycles with !out_valid
// -----------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = PAYLOAD_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    skid_state_e       r_state_p1;
    skid_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_main_data_p1;
    logic [DATA_W-1:0] r_skid_data_p1;

    logic w_main_vld_p1;
    logic w_skid_vld_p1;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_main_load;
    logic w_main_from_skid;
    logic w_skid_load;

    assign w_main_vld_p1 = r_state_p1[0];
    assign w_skid_vld_p1 = r_state_p1[1];

    assign in_ready   = !w_skid_vld_p1;
    assign out_valid  = w_main_vld_p1;
    assign out_data   = r_main_data_p1;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_state_nxt      = r_state_p1;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state_p1)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = FULL;
                    w_main_load = 1'b1;
                end
            end
            FULL: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_load = 1'b1;
                end else if (w_in_xfer) begin
                    // Downstream is stalled, so the new entry parks in the skid slot.
                    w_state_nxt = SKID;
                    w_skid_load = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = EMPTY;
                end
            end
            SKID: begin
                if (w_out_xfer) begin
                    w_state_nxt      = FULL;
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Flush drops the held entries and any incoming one. A transfer already
        // accepted downstream this cycle still completes, because out_xfer is
        // seen by the consumer independently of this state update.
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_load = 1'b0;
            w_skid_load = 1'b0;
        end
    end

    // ---- stage p1: occupancy and payload registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_p1 <= EMPTY;
        end else begin
            r_state_p1 <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_data_p1 <= '0;
            r_skid_data_p1 <= '0;
        end else begin
            if (w_main_load) begin
                r_main_data_p1 <= w_main_from_skid ? r_skid_data_p1 : in_data;
            end
            if (w_skid_load) begin
                r_skid_data_p1 <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic w_stall_inc;
    logic w_bubble_inc;

    assign w_stall_inc  = out_valid && !out_ready;
    assign w_bubble_inc = !out_valid;

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_bubble_inc),
        .count (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int DATA_W = 104;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the stage is a FIFO of capacity two. It accepts while
    // it holds fewer than two entries and presents its head when non-empty.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] dq[$];
    int  m_stall  = 0;
    int  m_bubble = 0;
    bit  m_ov;
    bit  m_ir;
    bit  chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            m_ov = (mq.size() > 0);
            m_ir = (mq.size() < 2);
            if (m_ov && !out_ready && m_stall < CMAX) m_stall++;
            if (!m_ov && m_bubble < CMAX) m_bubble++;
            if (m_ov && out_ready) dq.push_back(mq[0]);
            if (flush) begin
                mq.delete();
            end else begin
                if (m_ov && out_ready) void'(mq.pop_front());
                if (in_valid && m_ir) mq.push_back(in_data);
            end
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_out_valid", out_valid, (mq.size() > 0));
            chk("cyc_in_ready", in_ready, (mq.size() < 2));
            if (mq.size() > 0) chk("cyc_out_data", out_data, mq[0]);
`ifdef PIPE_STAGE_PERF_EN
            chk("cyc_stall_cnt", stall_cnt, m_stall);
            chk("cyc_bubble_cnt", bubble_cnt, m_bubble);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 'h99; out_ready = 1'b0;

        // Reset held two cycles with in_valid asserted
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
`ifdef PIPE_STAGE_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_bubble_cnt", bubble_cnt, 0);
`endif

        // Streaming at full rate
        rst = 1'b0; out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = DATA_W'(k);
            tick();
            chk("stream_out_valid", out_valid, 1);
            chk("stream_out_data", out_data, k);
            chk("stream_in_ready", in_ready, 1);
        end
        in_valid = 1'b0; in_data = 'x;
        tick();
        chk("stream_drain", out_valid, 0);
        tick();
        chk("x_data_no_valid", out_valid, 0);
        chk("stream_delivered", dq.size(), 4);
        if (dq.size() == 4) chk("stream_order", dq[3], 4);

        // Stall fills main then skid; release delivers in order
        dq.delete();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 'hA;
        tick();
        chk("stall_full_data", out_data, 'hA);
        chk("stall_full_ready", in_ready, 1);
        in_data = 'hB;
        tick();
        chk("stall_skid_ready", in_ready, 0);
        chk("stall_skid_data", out_data, 'hA);
        in_data = 'hE;
        tick();
        chk("stall_hold_data", out_data, 'hA);
        chk("stall_hold_ready", in_ready, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("release_first", out_data, 'hB);
        tick();
        chk("release_empty", out_valid, 0);
        chk("release_count", dq.size(), 2);
        if (dq.size() == 2) begin
            chk("release_a", dq[0], 'hA);
            chk("release_b", dq[1], 'hB);
        end

        // Flush while in SKID with a new entry offered
        dq.delete();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 'h11;
        tick();
        in_data = 'h12;
        tick();
        chk("pre_flush_ready", in_ready, 0);
        flush = 1'b1; in_data = 'hC;
        tick();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk("flush_nothing_out", dq.size(), 0);
        chk("flush_still_empty", out_valid, 0);

        // Flush coinciding with an output transfer
        dq.delete();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 'hD;
        tick();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flushx_empty", out_valid, 0);
        chk("flushx_delivered", dq.size(), 1);
        if (dq.size() == 1) chk("flushx_data", dq[0], 'hD);

        // Long stall: the stall counter saturates and bubbles stop counting
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 'h5;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("long_stall_data", out_data, 'h5);
        chk("long_stall_valid", out_valid, 1);
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_saturated", stall_cnt, 15);
        chk("bubble_frozen", bubble_cnt, 1);
`endif
        out_ready = 1'b1;
        tick();
        tick();
        chk("final_empty", out_valid, 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
